soric_bus_responder: RTL and testbench

- Slave-side endpoint of the req/gnt/rvalid data-bus protocol, one instance per interconnect slave port.
- Accepts requests, inserts a configurable number of grant wait states, and drives a single-port synchronous SRAM macro.
- Returns exactly one rvalid response per accepted request, for reads and writes, at fixed latency.
- The protocol has no response backpressure, so responses can never stall.

---
 rtl/soric_bus_pkg.sv | 23 ++
 rtl/soric_resp_pipe.sv | 30 +++
 rtl/soric_bus_responder.sv | 97 +++++++++
 tb/tb_soric_bus_responder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/soric_bus_pkg.sv
// rtl/soric_bus_pkg.sv - shared constants, response tag type and legality checks for the bus responder
package soric_bus_pkg;

  localparam int BUS_DATA_WIDTH = 32;
  localparam int BUS_BE_WIDTH = BUS_DATA_WIDTH / 8;
  localparam logic [31:0] BUS_ERR_RDATA = 32'hDEADBEEF;
  localparam int WAIT_CNT_WIDTH = 3;

  typedef struct packed {
    logic valid;
    logic is_read;
    logic oor;
  } resp_tag_t;

  function automatic bit read_latency_ok(input int lat);
    return (lat >= 1) && (lat <= 4);
  endfunction

  function automatic bit wait_states_ok(input int ws);
    return (ws >= 0) && (ws <= 7);
  endfunction

endpackage

// File: rtl/soric_resp_pipe.sv
// rtl/soric_resp_pipe.sv - fixed-depth response tag delay line with synchronous clear
module soric_resp_pipe
  import soric_bus_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  resp_tag_t tag_in,
  output resp_tag_t tag_out
);

  resp_tag_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/soric_bus_responder.sv
// rtl/soric_bus_responder.sv - req/gnt/rvalid slave endpoint with grant wait states driving a single-port SRAM
module soric_bus_responder
  import soric_bus_pkg::*;
#(
  parameter int DATA_WIDTH = BUS_DATA_WIDTH,
  parameter int ADDR_WIDTH = 10,
  parameter int MEM_WORDS = 256,
  parameter int READ_LATENCY = 1,
  parameter int WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(BUS_ERR_RDATA),
  localparam int BE_WIDTH = DATA_WIDTH / (BUS_DATA_WIDTH / BUS_BE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [BE_WIDTH-1:0]   mem_wmask_o,
  output logic [ADDR_WIDTH-3:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  if (!read_latency_ok(READ_LATENCY)) begin : g_bad_read_latency
    $error("READ_LATENCY must be in 1..4");
  end
  if (!wait_states_ok(WAIT_STATES)) begin : g_bad_wait_states
    $error("WAIT_STATES must be in 0..7");
  end

  localparam logic [31:0] MEM_WORDS_U = 32'(MEM_WORDS);

  logic [WAIT_CNT_WIDTH-1:0] wcnt;
  logic [ADDR_WIDTH-3:0]     word_idx;
  logic                      in_range;
  logic                      accept;
  resp_tag_t                 tag_in;
  resp_tag_t                 tag_out;
  logic                      unused_addr_lsb;

  assign word_idx        = addr_i[ADDR_WIDTH-1:2];
  assign unused_addr_lsb = ^addr_i[1:0];
  assign in_range        = 32'(word_idx) < MEM_WORDS_U;

  // Grant depends only on req_i, the wait counter and reset: no path from the response side.
  assign gnt_o  = req_i & (wcnt == WAIT_CNT_WIDTH'(WAIT_STATES)) & ~rst;
  assign accept = req_i & gnt_o;

  always_ff @(posedge clk) begin
    if (rst || !req_i || gnt_o) begin
      wcnt <= '0;
    end else begin
      wcnt <= wcnt + WAIT_CNT_WIDTH'(1);
    end
  end

  always_comb begin
    mem_en_o    = accept & in_range;
    mem_we_o    = mem_en_o & we_i;
    mem_wmask_o = mem_we_o ? be_i : '0;
    mem_addr_o  = word_idx;
    mem_wdata_o = wdata_i;
  end

  always_comb begin
    tag_in         = '0;
    tag_in.valid   = accept;
    tag_in.is_read = accept & ~we_i;
    tag_in.oor     = accept & ~in_range;
  end

  soric_resp_pipe #(
    .DEPTH(READ_LATENCY)
  ) u_resp_pipe (
    .clk    (clk),
    .rst    (rst),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  // Responses are masked during reset so a tag still in the last stage never escapes.
  always_comb begin
    rvalid_o = tag_out.valid & ~rst;
    rdata_o  = '0;
    if (rvalid_o && tag_out.is_read) begin
      rdata_o = tag_out.oor ? ERR_RDATA : mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_soric_bus_responder.sv
// tb/tb_soric_bus_responder.sv - randomized scoreboard bench over several responder configurations
module tb_soric_bus_responder;

  localparam int N_CFG = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;
  int n_done = 0;

  function automatic int ws_of(input int g);
    case (g)
      0: return 0;
      1: return 2;
      2: return 0;
      default: return 7;
    endcase
  endfunction

  function automatic int rl_of(input int g);
    return g + 1;
  endfunction

  function automatic int mw_of(input int g);
    case (g)
      0: return 256;
      1: return 256;
      2: return 128;
      default: return 200;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  for (genvar g = 0; g < N_CFG; g++) begin : g_cfg
    localparam int WS = ws_of(g);
    localparam int RL = rl_of(g);
    localparam int MW = mw_of(g);

    logic        rst, req, we;
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_wmask;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] sram [256];
    logic [31:0] rd_pipe [RL];
    logic [31:0] ref_mem [256];
    exp_t        q[$];
    exp_t        mon_e;

    soric_bus_responder #(
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (10),
      .MEM_WORDS   (MW),
      .READ_LATENCY(RL),
      .WAIT_STATES (WS),
      .ERR_RDATA   (32'hDEADBEEF)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_i      (req),
      .addr_i     (addr),
      .we_i       (we),
      .be_i       (be),
      .wdata_i    (wdata),
      .gnt_o      (gnt),
      .rvalid_o   (rvalid),
      .rdata_o    (rdata),
      .mem_en_o   (mem_en),
      .mem_we_o   (mem_we),
      .mem_wmask_o(mem_wmask),
      .mem_addr_o (mem_addr),
      .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata)
    );

    // SRAM macro: byte-masked write, read data READ_LATENCY cycles after the strobe.
    always @(posedge clk) begin
      if (mem_en) begin
        if (mem_we) begin
          for (int b = 0; b < 4; b++) begin
            if (mem_wmask[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
          end
        end
        rd_pipe[0] <= sram[mem_addr];
      end
      for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RL-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      check($sformatf("cfg%0d %s", g, name), act, exp);
    endtask

    task automatic idle(input int n);
      repeat (n) begin
        @(posedge clk);
        #1 req = 1'b0;
      end
    endtask

    task automatic issue(input logic w, input logic [9:0] a, input logic [3:0] b, input logic [31:0] d);
      int         waited;
      logic [7:0] idx;
      bit         inr;
      exp_t       e;
      idx = a[9:2];
      inr = (int'(idx) < MW);
      @(posedge clk);
      #1;
      req = 1'b1; we = w; addr = a; be = b; wdata = d;
      waited = 0;
      @(negedge clk);
      while (!gnt && waited < 20) begin
        chk("mem_en_without_accept", mem_en, 0);
        @(negedge clk);
        waited++;
      end
      chk("grant_wait_cycles", waited, WS);
      if (gnt) begin
        chk("mem_en", mem_en, inr);
        if (inr) begin
          chk("mem_addr", mem_addr, idx);
          chk("mem_we", mem_we, w);
          chk("mem_wmask", mem_wmask, w ? b : 4'b0000);
          if (w) chk("mem_wdata", mem_wdata, d);
        end
        if (w) begin
          if (inr) begin
            for (int k = 0; k < 4; k++) begin
              if (b[k]) ref_mem[idx][8*k +: 8] = d[8*k +: 8];
            end
          end
          e.data = 32'h0;
        end else begin
          e.data = inr ? ref_mem[idx] : 32'hDEADBEEF;
        end
        e.due = cyc + RL;
        q.push_back(e);
      end
    endtask

    task automatic drop_test();
      int h;
      h = $urandom_range(0, WS);
      idle(1);
      for (int i = 0; i < h; i++) begin
        @(posedge clk);
        #1;
        req = 1'b1; we = 1'b0; addr = {4'($urandom), 6'($urandom)};
        @(negedge clk);
        chk("gnt_before_wait_done", gnt, 0);
        chk("mem_en_before_wait_done", mem_en, 0);
      end
      idle(1);
      @(negedge clk);
      chk("gnt_with_req_low", gnt, 0);
    endtask

    always @(negedge clk) begin
      if (rst) begin
        chk("rst_gnt", gnt, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_en", mem_en, 0);
      end else if (rvalid) begin
        if (q.size() == 0) begin
          chk("rvalid_unexpected", rvalid, 0);
        end else begin
          mon_e = q.pop_front();
          chk("rdata", rdata, mon_e.data);
          chk("rvalid_cycle", cyc, mon_e.due);
        end
      end else begin
        chk("rdata_idle", rdata, 0);
      end
    end

    initial begin
      rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 16; i++) issue(1'b1, 10'(i * 4), 4'hF, $urandom);
      for (int i = 250; i < 256; i++) issue(1'b1, 10'(i * 4), 4'hF, $urandom);
      idle(1);

      issue(1'b1, 10'h010, 4'hF, 32'h12345678);
      issue(1'b0, 10'h010, 4'hF, 32'h0);
      issue(1'b1, 10'h020, 4'hF, 32'h0);
      issue(1'b1, 10'h020, 4'b0101, 32'hAABBCCDD);
      issue(1'b0, 10'h020, 4'h0, 32'h0);
      issue(1'b1, 10'h024, 4'h0, 32'hFFFFFFFF);
      issue(1'b0, 10'h024, 4'hF, 32'h0);
      idle(2);

      issue(1'b0, 10'h000, 4'hF, 32'h0);
      issue(1'b0, 10'h004, 4'hF, 32'h0);
      issue(1'b0, 10'h008, 4'hF, 32'h0);
      issue(1'b0, 10'h3FC, 4'hF, 32'h0);
      issue(1'b1, 10'h3F8, 4'hF, 32'h55AA55AA);
      issue(1'b0, 10'h3F8, 4'hF, 32'h0);

      for (int i = 0; i < 3; i++) begin
        drop_test();
        issue(1'b0, 10'h004, 4'hF, 32'h0);
      end

      idle(RL + 2);
      issue(1'b0, 10'h004, 4'hF, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1; req = 1'b1; we = 1'b0; addr = 10'h008;
      q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0; req = 1'b0;

      for (int n = 0; n < 80; n++) begin
        logic [7:0] idx;
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        idx = ($urandom_range(0, 7) < 6) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(250, 255));
        issue(1'($urandom), {idx, 2'($urandom)}, 4'($urandom), $urandom);
      end

      idle(1);
      for (int c = 0; c < 50 && q.size() > 0; c++) @(posedge clk);
      chk("pending_responses_at_end", q.size(), 0);
      n_done++;
    end
  end

  initial begin
    for (int c = 0; c < 60000 && n_done < N_CFG; c++) @(posedge clk);
    check("configs_completed", n_done, N_CFG);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
